// File: rtl/ifid_pipe_reg.sv
// ifid_pipe_reg: IF/ID pipeline latch between the instruction-memory
// interface and the decode stage.
//
// Ports:
//   CLK, RST        clock (rising edge) and synchronous active-high reset
//   ihit            instruction memory returned a word this cycle
//   imemload        fetched instruction word
//   pc_in, npc_in   PC of imemload and PC+4
//   stall_ifid      hold the latch contents
//   flush_ifid      squash the latch contents
//   instr_out       latched instruction, NOP_WORD for a bubble
//   pc_out, npc_out latched PC and PC+4
//   valid_out       1 = real instruction, 0 = bubble
//   squash_pending  a flushed fetch is still outstanding
//   bubble_cnt      saturating count of inserted bubbles
module ifid_pipe_reg #(
  parameter logic [31:0] NOP_WORD = 32'h00000000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic [31:0]      imemload,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      npc_in,
  input  logic             stall_ifid,
  input  logic             flush_ifid,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc_out,
  output logic [31:0]      npc_out,
  output logic             valid_out,
  output logic             squash_pending,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      npc_q, npc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bubble;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    bubble  = 1'b0;

    if (flush_ifid) begin
      bubble = 1'b1;
      // A flush with no word in hand leaves the fetch outstanding; once in
      // SQUASH, a further flush keeps us there regardless of ihit.
      if (state_q == RUN && !ihit) begin
        state_d = SQUASH;
      end
    end else if (stall_ifid) begin
      // Hold everything; upstream holds the PC so the word is refetched.
    end else begin
      unique case (state_q)
        RUN: begin
          if (ihit) begin
            instr_d = imemload;
            pc_d    = pc_in;
            npc_d   = npc_in;
            valid_d = 1'b1;
          end else begin
            bubble = 1'b1;
          end
        end
        SQUASH: begin
          // The word arriving here belongs to the flushed path: drop it.
          bubble = 1'b1;
          if (ihit) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    if (bubble) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bubble && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_out      = instr_q;
  assign pc_out         = pc_q;
  assign npc_out        = npc_q;
  assign valid_out      = valid_q;
  assign squash_pending = (state_q == SQUASH);
  assign bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_ifid_pipe_reg.sv
module tb_ifid_pipe_reg;

  localparam logic [31:0] NOP_B = 32'hDEADBEEF;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall_ifid, flush_ifid;
  logic [31:0] imemload, pc_in, npc_in;

  logic [31:0] instr_a, pc_a, npc_a;
  logic        valid_a, pend_a;
  logic [15:0] cnt_a;

  logic [31:0] instr_b, pc_b, npc_b;
  logic        valid_b, pend_b;
  logic [3:0]  cnt_b;

  always #5 CLK = ~CLK;

  ifid_pipe_reg dut_a (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .pc_in(pc_in), .npc_in(npc_in), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .instr_out(instr_a), .pc_out(pc_a),
    .npc_out(npc_a), .valid_out(valid_a), .squash_pending(pend_a),
    .bubble_cnt(cnt_a)
  );

  ifid_pipe_reg #(.NOP_WORD(NOP_B), .CNT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .pc_in(pc_in), .npc_in(npc_in), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .instr_out(instr_b), .pc_out(pc_b),
    .npc_out(npc_b), .valid_out(valid_b), .squash_pending(pend_b),
    .bubble_cnt(cnt_b)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
    logic        pend;
    int          cnt_a;
    int          cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: the last real instruction captured, whether a wrong-path
  // fetch is still owed to us, and plain integer bubble tallies clipped to max.
  logic [31:0] m_word, m_pc, m_npc;
  logic        m_valid, m_pend;
  int          m_cnt_a, m_cnt_b;

  task automatic model_bubble();
    m_valid = 1'b0;
    m_cnt_a = (m_cnt_a + 1 > 65535) ? 65535 : m_cnt_a + 1;
    m_cnt_b = (m_cnt_b + 1 > 15) ? 15 : m_cnt_b + 1;
  endtask

  task automatic cycle(input logic rst, input logic hit, input logic [31:0] w,
                       input logic [31:0] pc, input logic stall, input logic flush);
    exp_t e;
    @(negedge CLK);
    RST = rst; ihit = hit; imemload = w; pc_in = pc; npc_in = pc + 32'd4;
    stall_ifid = stall; flush_ifid = flush;
    if (rst) begin
      m_valid = 1'b0; m_pend = 1'b0; m_pc = '0; m_npc = '0;
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (flush) begin
      if (!m_pend && !hit) m_pend = 1'b1;
      model_bubble();
    end else if (stall) begin
      // nothing changes
    end else if (m_pend) begin
      if (hit) m_pend = 1'b0;
      model_bubble();
    end else if (hit) begin
      m_word = w; m_pc = pc; m_npc = pc + 32'd4; m_valid = 1'b1;
    end else begin
      model_bubble();
    end
    e.word = m_word; e.pc = m_pc; e.npc = m_npc; e.valid = m_valid;
    e.pend = m_pend; e.cnt_a = m_cnt_a; e.cnt_b = m_cnt_b;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, got, want);
    end
  endtask

  // Monitor: every edge the latch presents a new output set; compare it
  // against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("instr_a", instr_a, e.valid ? e.word : 32'h0);
        chk("instr_b", instr_b, e.valid ? e.word : NOP_B);
        chk("pc_a",    pc_a,    e.pc);
        chk("npc_a",   npc_a,   e.npc);
        chk("pc_b",    pc_b,    e.pc);
        chk("npc_b",   npc_b,   e.npc);
        chk("valid_a", {31'b0, valid_a}, {31'b0, e.valid});
        chk("valid_b", {31'b0, valid_b}, {31'b0, e.valid});
        chk("squash_a", {31'b0, pend_a}, {31'b0, e.pend});
        chk("squash_b", {31'b0, pend_b}, {31'b0, e.pend});
        chk("cnt_a", {16'b0, cnt_a}, 32'(e.cnt_a));
        chk("cnt_b", {28'b0, cnt_b}, 32'(e.cnt_b));
      end
    end
  end

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = '0; pc_in = '0; npc_in = '0;
    stall_ifid = 1'b0; flush_ifid = 1'b0;
    m_word = '0; m_pc = '0; m_npc = '0; m_valid = 1'b0; m_pend = 1'b0;
    m_cnt_a = 0; m_cnt_b = 0;

    // reset, then a normal capture
    cycle(1, 0, 32'h0, 32'h0, 0, 0);
    cycle(1, 0, 32'h0, 32'h0, 0, 0);
    cycle(0, 1, 32'h8C220004, 32'h10, 0, 0);
    // stall hold while a different word is offered
    for (int unsigned i = 0; i < 3; i++) cycle(0, 1, 32'h20010005, 32'h14, 1, 0);
    // flush with concurrent hit: word dropped, no squash pending
    cycle(0, 1, 32'hAAAA0000, 32'h18, 0, 1);
    // flush with fetch outstanding, late wrong-path word, then good word
    cycle(0, 0, 32'h0, 32'h1C, 0, 1);
    cycle(0, 0, 32'h0, 32'h1C, 0, 0);
    cycle(0, 0, 32'h0, 32'h1C, 0, 0);
    cycle(0, 1, 32'h12340000, 32'h1C, 0, 0);
    cycle(0, 1, 32'h00221820, 32'h40, 0, 0);
    // enter SQUASH, flush+stall together, then reset clears it
    cycle(0, 0, 32'h0, 32'h44, 0, 1);
    cycle(0, 1, 32'h0BAD0BAD, 32'h44, 1, 1);
    cycle(0, 0, 32'h0, 32'h44, 1, 0);
    cycle(1, 1, 32'h0BAD0BAD, 32'h44, 0, 0);
    cycle(0, 1, 32'h3C01ABCD, 32'h80, 0, 0);
    // saturate the 4-bit counter
    for (int unsigned i = 0; i < 20; i++) cycle(0, 0, 32'h0, 32'h84, 0, 0);

    // randomized traffic
    for (int unsigned i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
            $urandom(), $urandom() & 32'hFFFF_FFFC,
            ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
    end

    @(posedge CLK);
    @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ifid_pipe_reg.md
Name: ifid_pipe_reg

Overview:
- IF/ID pipeline latch. It is the consumer of the hazard unit's `stall_ifid`/`flush_ifid` controls.
- Captures the fetched instruction and its PC on `ihit`, and inserts bubbles when no instruction is available.
- Tracks fetches that were flushed while still in flight, so a late-returning wrong-path instruction is discarded.
- Sits between the instruction-memory interface and the decode stage.
- Also keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- `NOP_WORD`, 32'h00000000, instruction word driven on `instr_out` for a bubble (sll $0,$0,0).
- `CNT_W`, 16, width of the bubble counter.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  synchronous reset, active-high.
- `ihit`  in  1  instruction memory returned a valid word this cycle.
- `imemload`  in  32  fetched instruction word.
- `pc_in`  in  32  PC of the word on `imemload`.
- `npc_in`  in  32  `pc_in`+4 from the fetch stage.
- `stall_ifid`  in  1  hold the latch contents.
- `flush_ifid`  in  1  squash the latch contents.
- `instr_out`  out  32  latched instruction, or `NOP_WORD`.
- `pc_out`  out  32  latched PC.
- `npc_out`  out  32  latched PC+4.
- `valid_out`  out  1  1 = real instruction, 0 = bubble.
- `squash_pending`  out  1  1 = a flushed fetch is still outstanding.
- `bubble_cnt`  out  `CNT_W`  saturating count of bubbles inserted.

Behaviour:
- All state updates on rising `CLK`. Outputs come straight from registers. Capture latency is 1 cycle (value visible the cycle after the edge).
- Reset (`RST`=1 at the edge):
  - `instr_out`=`NOP_WORD`; `pc_out`, `npc_out`, `valid_out`, `bubble_cnt` = 0.
  - State = RUN, `squash_pending`=0.
  - Reset mid-operation discards any pending squash.
- Per-edge priority: `RST` > `flush_ifid` > `stall_ifid` > load/bubble.
- FSM states: RUN, SQUASH (`squash_pending`=1 only in SQUASH).
- RUN:
  - `flush_ifid`=1: latch becomes a bubble (`instr_out`=`NOP_WORD`, `valid_out`=0; `pc_out`/`npc_out` hold their old values).
    - `ihit`=0 the same cycle: go to SQUASH.
    - `ihit`=1 the same cycle: the arriving word is discarded and the state stays RUN.
  - `stall_ifid`=1 (no flush): all latch fields hold. `ihit` is ignored, because upstream `pc_en` holds the PC and the word is refetched. State and counter are unchanged.
  - `ihit`=1, no flush, no stall: capture `imemload`, `pc_in`, `npc_in`; `valid_out`=1.
  - `ihit`=0, no flush, no stall: insert a bubble.
- SQUASH:
  - `flush_ifid`=1: stay in SQUASH; latch is a bubble.
  - `stall_ifid`=1 (no flush): hold latch and state.
  - `ihit`=1: the arriving word is discarded, latch is a bubble, go to RUN.
  - `ihit`=0: bubble, stay in SQUASH.
- Bubble counter:
  - Increments by 1 on every edge where the latch is written as a bubble (flush, no-ihit, or a squashed word).
  - Does not increment on a stall-hold.
  - Saturates at all-ones and never wraps.
- `valid_out`=0 always pairs with `instr_out`=`NOP_WORD`. Downstream never sees a partial bubble.

Test Plan:
- Reset then RUN: `RST`=1 for 2 cycles, release; `ihit`=1, `imemload`=32'h8C220004, `pc_in`=32'h00000010, `npc_in`=32'h00000014 -> next cycle `instr_out`=32'h8C220004, `pc_out`=0x10, `npc_out`=0x14, `valid_out`=1, `bubble_cnt`=0.
- Stall hold: latch holds 32'h8C220004; `stall_ifid`=1 for 3 cycles with `ihit`=1, `imemload`=32'h20010005 -> `instr_out` stays 32'h8C220004, `valid_out`=1, `bubble_cnt` unchanged.
- Flush with concurrent hit: `flush_ifid`=1, `ihit`=1, `imemload`=32'hAAAA0000 -> `instr_out`=0, `valid_out`=0, `squash_pending`=0, `bubble_cnt`+1.
- Flush while fetch outstanding:
  - `flush_ifid`=1 with `ihit`=0 -> `squash_pending`=1.
  - 2 cycles of `ihit`=0 -> bubbles.
  - Then `ihit`=1 with `imemload`=32'h12340000 -> discarded, `valid_out`=0, `squash_pending`=0.
  - Next `ihit`=1 with 32'h00221820 -> captured, `valid_out`=1.
  - `bubble_cnt` rises by 4.
- Priority/reset in SQUASH: in SQUASH, `flush_ifid`=1 and `stall_ifid`=1 together -> bubble, stays SQUASH. Then `RST`=1 -> `squash_pending`=0, all outputs zero. Next `ihit`=1 word is captured normally.
- Counter saturation (`CNT_W`=4): 20 consecutive `ihit`=0 cycles -> `bubble_cnt` reaches 4'hF and holds there; no wrap.
